// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: clock inhibit, request-to-send, device-clocked
// data/parity/stop shifting, ACK sampling and inter-edge timeout, via pull-low enables.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_prev_q;
  logic [8:0]    frame_q, frame_d;
  logic [3:0]    idx_q, idx_d;
  logic          dbit_q, dbit_d;
  logic          nack_q, nack_d;
  logic [IW-1:0] icnt_q, icnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic clk_s, data_s, fall, watched, timeout;

  assign clk_s   = clk_sync_q[1];
  assign data_s  = data_sync_q[1];
  assign fall    = clk_prev_q & ~clk_s;
  assign watched = state_q inside {S_SEND, S_ACK, S_WAIT_IDLE};
  assign timeout = watched && !fall && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      frame_q     <= '0;
      idx_q       <= '0;
      dbit_q      <= 1'b0;
      nack_q      <= 1'b0;
      icnt_q      <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_prev_q  <= clk_s;
      frame_q     <= frame_d;
      idx_q       <= idx_d;
      dbit_q      <= dbit_d;
      nack_q      <= nack_d;
      icnt_q      <= icnt_d;
      tcnt_q      <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    dbit_d  = dbit_q;
    nack_d  = nack_q;
    icnt_d  = icnt_q;
    tcnt_d  = tcnt_q;
    if (watched) begin
      tcnt_d = fall ? '0 : tcnt_q + TW'(1);
    end
    unique case (state_q)
      // DONE already reports busy=0, so a request there is accepted like in IDLE
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (tx_start) begin
          frame_d = {~^tx_data, tx_data};
          nack_d  = 1'b0;
          icnt_d  = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (icnt_q == IW'(INHIBIT_CYCLES - 1)) begin
          state_d = S_REQ;
        end else begin
          icnt_d = icnt_q + IW'(1);
        end
      end
      S_REQ: begin
        state_d = S_SEND;
        dbit_d  = 1'b1;
        idx_d   = '0;
        tcnt_d  = '0;
      end
      S_SEND: begin
        if (fall) begin
          if (idx_q == 4'd9) begin
            dbit_d  = 1'b0;
            state_d = S_ACK;
          end else begin
            dbit_d = ~frame_q[idx_q];
            idx_d  = idx_q + 4'd1;
          end
        end
      end
      S_ACK: begin
        if (fall) begin
          nack_d  = data_s;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout) begin
      state_d = S_DONE;
      nack_d  = 1'b1;
      dbit_d  = 1'b0;
    end
  end

  always_comb begin
    ps2_clk_oe  = state_q inside {S_INHIBIT, S_REQ};
    ps2_data_oe = (state_q == S_REQ) || ((state_q == S_SEND) && dbit_q);
    busy        = !(state_q inside {S_IDLE, S_DONE});
    done        = (state_q == S_DONE);
    err         = (state_q == S_DONE) && nack_q;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a cycle-stepped PS/2 device model receives each frame and
// ACKs/NACKs or stalls; results are checked against a popcount-based frame reference.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 100;
  localparam int unsigned TMO  = 5000;
  localparam int unsigned HALF = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, err;
  logic       dev_clk_low, dev_data_low;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Expected line levels: start, 8 data bits LSB first, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
  endtask

  task automatic watch_inhibit(output int unsigned n_inh, output int unsigned n_req);
    n_inh = 0;
    n_req = 0;
    while (ps2_clk_oe && !ps2_data_oe && n_inh < 1000) begin
      n_inh++;
      step();
    end
    while (ps2_clk_oe && ps2_data_oe && n_req < 10) begin
      n_req++;
      step();
    end
  endtask

  task automatic device(input bit nack, input int unsigned npulses, input int unsigned half,
                        input bit inject, input logic [7:0] inj,
                        output logic [10:0] bits, output int unsigned fall_cyc,
                        output int unsigned oe_viol, output bit lost);
    int unsigned w;
    bits = '0; fall_cyc = 0; oe_viol = 0; lost = 1'b0; w = 0;
    while (!(ps2_clk_in && !ps2_data_in) && w < 50) begin
      step();
      w++;
    end
    if (w >= 50) begin
      lost = 1'b1;
      return;
    end
    bits[0] = ps2_data_in;
    for (int unsigned k = 1; k <= npulses; k++) begin
      for (int unsigned j = 0; j < half; j++) begin
        if (inject && k == 3 && j == 0) begin
          tx_data  = inj;
          tx_start = 1'b1;
        end else begin
          tx_start = 1'b0;
        end
        if (k == 11 && (ps2_clk_oe || ps2_data_oe)) oe_viol++;
        step();
      end
      tx_start    = 1'b0;
      dev_clk_low = 1'b1;
      if (k == 11 && !nack) dev_data_low = 1'b1;
      fall_cyc = cyc;
      for (int unsigned j = 0; j < half; j++) begin
        if (k == 11 && (ps2_clk_oe || ps2_data_oe)) oe_viol++;
        step();
      end
      if (k <= 10) bits[k] = ps2_data_in;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_done(input bit chk_oe, input int unsigned limit,
                           output bit got, output bit err_v, output bit busy_at,
                           output bit busy_bef, output int unsigned done_cyc,
                           output bit coe_at, output bit doe_at, output bit done_next,
                           output int unsigned oe_viol);
    int unsigned w;
    w = 0; got = 1'b0; err_v = 1'b0; busy_at = 1'b1; busy_bef = busy;
    done_cyc = 0; coe_at = 1'b1; doe_at = 1'b1; done_next = 1'b1; oe_viol = 0;
    while (!done && w < limit) begin
      busy_bef = busy;
      if (chk_oe && (ps2_clk_oe || ps2_data_oe)) oe_viol++;
      step();
      w++;
    end
    if (done) begin
      got      = 1'b1;
      err_v    = err;
      busy_at  = busy;
      coe_at   = ps2_clk_oe;
      doe_at   = ps2_data_oe;
      done_cyc = cyc;
      step();
      done_next = done;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (4) step();
    rst = 1'b0;
    step();
    checks++; if (ps2_clk_oe !== 1'b0) begin failures++; $display("FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); end
    checks++; if (ps2_data_oe !== 1'b0) begin failures++; $display("FAIL reset_data_oe: got %b expected 0", ps2_data_oe); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
  endtask

  task automatic test_frame(input string tag, input logic [7:0] d, input bit nack,
                            input int unsigned half);
    int unsigned n_inh, n_req, fcyc, viol_dev, viol_wait, dcyc;
    logic [10:0] bits, exp_bits;
    bit lost, got, errv, busy_at, busy_bef, coe_at, doe_at, done_next;
    logic send_clk, send_data, busy_acc;
    exp_bits = ref_frame(d);
    start_tx(d);
    busy_acc = busy;
    watch_inhibit(n_inh, n_req);
    send_clk  = ps2_clk_oe;
    send_data = ps2_data_oe;
    device(nack, 11, half, 1'b0, 8'h00, bits, fcyc, viol_dev, lost);
    wait_done(1'b1, 4 * half + 50, got, errv, busy_at, busy_bef, dcyc, coe_at, doe_at,
              done_next, viol_wait);
    checks++; if (busy_acc !== 1'b1) begin failures++; $display("FAIL %s busy_after_accept: got %b expected 1", tag, busy_acc); end
    checks++; if (n_inh !== INH) begin failures++; $display("FAIL %s inhibit_len: got %0d expected %0d", tag, n_inh, INH); end
    checks++; if (n_req !== 1) begin failures++; $display("FAIL %s req_len: got %0d expected 1", tag, n_req); end
    checks++; if ({send_clk, send_data} !== 2'b01) begin failures++; $display("FAIL %s send_entry_oe: got %b expected 01", tag, {send_clk, send_data}); end
    checks++; if (lost) begin failures++; $display("FAIL %s rts_seen: got 0 expected 1", tag); end
    checks++; if (bits !== exp_bits) begin failures++; $display("FAIL %s frame_bits: got %b expected %b", tag, bits, exp_bits); end
    checks++; if (viol_dev + viol_wait != 0) begin failures++; $display("FAIL %s oe_in_ack_wait: got %0d cycles expected 0", tag, viol_dev + viol_wait); end
    checks++; if (!got) begin failures++; $display("FAIL %s done_seen: got 0 expected 1", tag); end
    checks++; if (errv !== nack) begin failures++; $display("FAIL %s err: got %b expected %b", tag, errv, nack); end
    checks++; if ({busy_bef, busy_at} !== 2'b10) begin failures++; $display("FAIL %s busy_drop: got %b expected 10", tag, {busy_bef, busy_at}); end
    checks++; if (done_next !== 1'b0) begin failures++; $display("FAIL %s done_pulse_len: got %b expected 0", tag, done_next); end
  endtask

  task automatic test_parity_cases();
    test_frame("f4", 8'hF4, 1'b0, HALF);
    test_frame("ff", 8'hFF, 1'b0, HALF);
    test_frame("00", 8'h00, 1'b0, HALF);
  endtask

  task automatic test_nack();
    test_frame("nack", 8'hF4, 1'b1, HALF);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      test_frame("rand", 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(20, 60));
    end
  endtask

  task automatic test_timeout();
    int unsigned n_inh, n_req, fcyc, viol, viol_wait, dcyc;
    logic [10:0] bits, exp_bits;
    logic [4:0] got_head, exp_head;
    logic [7:0] d;
    bit lost, got, errv, busy_at, busy_bef, coe_at, doe_at, done_next;
    d = 8'($urandom);
    exp_bits = ref_frame(d);
    start_tx(d);
    watch_inhibit(n_inh, n_req);
    device(1'b0, 4, HALF, 1'b0, 8'h00, bits, fcyc, viol, lost);
    wait_done(1'b0, TMO + 200, got, errv, busy_at, busy_bef, dcyc, coe_at, doe_at,
              done_next, viol_wait);
    got_head = bits[4:0];
    exp_head = exp_bits[4:0];
    checks++; if (got_head !== exp_head) begin failures++; $display("FAIL tmo_head_bits: got %b expected %b", got_head, exp_head); end
    checks++; if (!got) begin failures++; $display("FAIL tmo_done_seen: got 0 expected 1"); end
    checks++; if (dcyc !== fcyc + 3 + TMO) begin failures++; $display("FAIL tmo_latency: got %0d expected %0d", dcyc - fcyc, 3 + TMO); end
    checks++; if (errv !== 1'b1) begin failures++; $display("FAIL tmo_err: got %b expected 1", errv); end
    checks++; if (busy_at !== 1'b0) begin failures++; $display("FAIL tmo_busy: got %b expected 0", busy_at); end
    checks++; if ({coe_at, doe_at} !== 2'b00) begin failures++; $display("FAIL tmo_oe: got %b expected 00", {coe_at, doe_at}); end
    test_frame("after_tmo", 8'hF4, 1'b0, HALF);
  endtask

  task automatic test_ignore_start();
    int unsigned fcyc, viol, viol_wait, dcyc, n_inh, n_req, stray;
    logic [10:0] bits, exp_bits;
    logic [7:0] d;
    bit lost, got, errv, busy_at, busy_bef, coe_at, doe_at, done_next;
    d = 8'($urandom);
    exp_bits = ref_frame(d);
    start_tx(d);
    watch_inhibit(n_inh, n_req);
    device(1'b0, 11, HALF, 1'b1, ~d, bits, fcyc, viol, lost);
    wait_done(1'b1, 4 * HALF + 50, got, errv, busy_at, busy_bef, dcyc, coe_at, doe_at,
              done_next, viol_wait);
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy || ps2_clk_oe) stray++;
      step();
    end
    checks++; if (bits !== exp_bits) begin failures++; $display("FAIL ign_frame_bits: got %b expected %b", bits, exp_bits); end
    checks++; if (!got || errv !== 1'b0) begin failures++; $display("FAIL ign_done_err: got %b%b expected 10", got, errv); end
    checks++; if (stray !== 0) begin failures++; $display("FAIL ign_no_queue: got %0d busy cycles expected 0", stray); end
  endtask

  task automatic test_reset_mid();
    int unsigned fcyc, viol, n_inh, n_req, spur;
    logic [10:0] bits;
    bit lost;
    start_tx(8'($urandom));
    watch_inhibit(n_inh, n_req);
    device(1'b0, 4, HALF, 1'b0, 8'h00, bits, fcyc, viol, lost);
    rst = 1'b1;
    step();
    checks++; if ({ps2_clk_oe, ps2_data_oe, busy, done} !== 4'b0000) begin failures++; $display("FAIL rstmid_outputs: got %b expected 0000", {ps2_clk_oe, ps2_data_oe, busy, done}); end
    rst = 1'b0;
    spur = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) spur++;
      step();
    end
    checks++; if (spur !== 0) begin failures++; $display("FAIL rstmid_no_done: got %0d cycles expected 0", spur); end
    test_frame("after_rst", 8'($urandom), 1'b0, HALF);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_parity_cases();
    test_nack();
    test_timeout();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
